sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Control unit for the SAP-1 datapath.
- Consumes the 6-state one-hot ring counter output `t` and the IR opcode nibble, and drives the 12-bit control word.
- Latches HLT and counts retired instructions.
- Shadow-tracks the ring counter and flags any illegal or out-of-order T-state.
- Sits between `ring_counter` and the bus/register datapath.

Parameters:
- CNT_W, 8, width of the retired-instruction counter
- HLT_OP, 4'hF, opcode that halts
- OUT_OP, 4'hE, opcode that loads the output register

Ports:
- clk  in  1  system clock; all state updates on rising edge
- res  in  1  asynchronous, active-high reset
- t  in  6  one-hot T-state from ring counter; t[0]=T1 … t[5]=T6
- opcode  in  4  IR[7:4]
- con  out  12  control word, MSB..LSB = Cp Ep Lm_n Ce_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
- hlt  out  1  registered halt flag
- ring_clr  out  1  early ring-counter clear request (see Optional Feature)
- fault  out  1  sticky T-state sequence error
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, res=1): hlt=0, fault=0, instr_cnt=0, exp_idx=0 (expects T1). `con` = IDLE = 12'h3E3 while `res` is high.
- `con` is combinational from `t`, `opcode` and `hlt`; zero latency within the T-state.
- Fetch, all opcodes:
  - T1 = 12'h5E3 (Ep, Lm_n=0)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (Ce_n=0, Li_n=0)
- LDA 4'h0: T4=1A3, T5=2C3, T6=3E3.
- ADD 4'h1: T4=1A3, T5=2E1, T6=3C7.
- SUB 4'h2: T4=1A3, T5=2E1, T6=3CF.
- OUT_OP: T4=3F2, T5=3E3, T6=3E3.
- HLT_OP, and all other opcodes (NOP): T4..T6 = 3E3.
- Halt:
  - On a rising edge with t[3]=1 and opcode==HLT_OP, `hlt` sets to 1.
  - `hlt` stays set until `res`. While hlt=1: con=3E3, instr_cnt frozen, exp_idx frozen, fault checking disabled.
- Sequence tracker:
  - Every rising edge with hlt=0: if t != onehot(exp_idx), or t is not exactly one-hot, `fault` sets (sticky until `res`).
  - exp_idx then advances mod 6, or goes to 0 if ring_clr=1.
  - No resynchronisation after a fault: exp_idx keeps free-running.
- Retire:
  - On a rising edge with hlt=0 and (exp_idx==5, or ring_clr=1), instr_cnt increments.
  - instr_cnt wraps from 2^CNT_W-1 to 0.
  - The HLT instruction itself does not retire: hlt sets at T4, before its end.
- Illegal t (zero or multi-hot): con=IDLE, ring_clr=0, fault set on that edge.
- `res` asserted mid-instruction: all state clears immediately; the first post-reset edge must see t=6'b000001.

Optional Feature:
- Macro: SAP_EARLY_RING_CLR_EN
- Defined: `ring_clr` is asserted combinationally in the last useful T-state, so the ring returns to T1 on the next edge.
  - T5 for LDA.
  - T4 for OUT_OP and NOP opcodes.
  - Never for ADD/SUB/HLT, and never while hlt=1.
  - The tracker expects T1 next, and the instruction retires on that edge.
- Undefined: `ring_clr` is tied to 0 and every instruction takes 6 states.

Decomposition:
- Package `sap_pkg` holds:
  - opcode constants (LDA/ADD/SUB/OUT/HLT)
  - control-word bit index constants
  - microword constants (IDLE, FETCH_T1..T3, etc.)
- Sub-module `sap_microcode_rom`: purely combinational (state index, opcode) → 12-bit word.
- Top holds hlt, fault, exp_idx, instr_cnt and the one-hot→index encode.

Test Plan:
- Reset then LDA (op 0) through T1..T6 → con = 5E3, BE3, 263, 1A3, 2C3, 3E3; instr_cnt=1; fault=0.
- SUB (op 2) cycle → T6 con=3CF; ADD at T6 → 3C7; instr_cnt increments once per instruction.
- HLT (op F) → hlt=1 after the T4 edge; con=3E3 thereafter regardless of t; instr_cnt unchanged; `res` pulse → hlt=0, con follows t.
- Force t=6'b000100 when T2 is expected → fault=1 after that edge and stays 1 across later correct states; cleared only by `res`.
- With SAP_EARLY_RING_CLR_EN: OUT (op E) → ring_clr=1 at T4, con=3F2; next edge t=T1 gives no fault and instr_cnt+1. Without the macro: ring_clr=0 throughout.
- CNT_W=2, five NOP instructions → instr_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 control unit: opcodes, control-word bit
// positions, T-state indices and the microwords driven onto the control bus.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    // All active-low strobes released, nothing driving the bus.
    localparam logic [11:0] MW_IDLE     = 12'h3E3;
    localparam logic [11:0] MW_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] MW_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] MW_FETCH_T3 = 12'h263;
    localparam logic [11:0] MW_MEM_T4   = 12'h1A3;
    localparam logic [11:0] MW_LDA_T5   = 12'h2C3;
    localparam logic [11:0] MW_ALU_T5   = 12'h2E1;
    localparam logic [11:0] MW_ADD_T6   = 12'h3C7;
    localparam logic [11:0] MW_SUB_T6   = 12'h3CF;
    localparam logic [11:0] MW_OUT_T4   = 12'h3F2;

    typedef enum logic [2:0] {
        TS_T1 = 3'd0,
        TS_T2 = 3'd1,
        TS_T3 = 3'd2,
        TS_T4 = 3'd3,
        TS_T5 = 3'd4,
        TS_T6 = 3'd5
    } tstate_e;

    function automatic logic is_onehot(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode lookup: (T-state index, opcode) -> 12-bit control word.
// Unknown opcodes and HLT behave as NOP after fetch.
module sap_microcode_rom
    import sap_pkg::*;
#(
    parameter logic [3:0] OUT_OP = OP_OUT
) (
    input  tstate_e     state_i,
    input  logic [3:0]  opcode_i,
    output logic [11:0] word_o
);

    always_comb begin
        word_o = MW_IDLE;
        case (state_i)
            TS_T1: word_o = MW_FETCH_T1;
            TS_T2: word_o = MW_FETCH_T2;
            TS_T3: word_o = MW_FETCH_T3;
            TS_T4: begin
                if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB)
                    word_o = MW_MEM_T4;
                else if (opcode_i == OUT_OP)
                    word_o = MW_OUT_T4;
            end
            TS_T5: begin
                if (opcode_i == OP_LDA)
                    word_o = MW_LDA_T5;
                else if (opcode_i == OP_ADD || opcode_i == OP_SUB)
                    word_o = MW_ALU_T5;
            end
            TS_T6: begin
                if (opcode_i == OP_ADD)
                    word_o = MW_ADD_T6;
                else if (opcode_i == OP_SUB)
                    word_o = MW_SUB_T6;
            end
            default: word_o = MW_IDLE;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control unit: microcode decode, halt latch, retired-instruction counter
// and ring-counter shadow tracker. Optional macro: SAP_EARLY_RING_CLR_EN.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int         CNT_W  = 8,
    parameter logic [3:0] HLT_OP = 4'hF,
    parameter logic [3:0] OUT_OP = 4'hE
) (
    input  logic             clk,
    input  logic             res,
    input  logic [5:0]       t,
    input  logic [3:0]       opcode,
    output logic [11:0]      con,
    output logic             hlt,
    output logic             ring_clr,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    logic             hlt_q, hlt_d;
    logic             fault_q, fault_d;
    logic [2:0]       exp_idx_q, exp_idx_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic        t_legal;
    logic [2:0]  t_idx;
    logic [11:0] rom_word;

    assign t_legal = is_onehot(t);
    assign t_idx   = onehot_index(t);

    sap_microcode_rom #(
        .OUT_OP (OUT_OP)
    ) u_rom (
        .state_i  (tstate_e'(t_idx)),
        .opcode_i (opcode),
        .word_o   (rom_word)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            hlt_q       <= 1'b0;
            fault_q     <= 1'b0;
            exp_idx_q   <= 3'd0;
            instr_cnt_q <= '0;
        end else begin
            hlt_q       <= hlt_d;
            fault_q     <= fault_d;
            exp_idx_q   <= exp_idx_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Tracker keeps free-running after a fault; only reset resynchronises it.
    always_comb begin
        hlt_d       = hlt_q;
        fault_d     = fault_q;
        exp_idx_d   = exp_idx_q;
        instr_cnt_d = instr_cnt_q;
        if (!hlt_q) begin
            if (t != (6'd1 << exp_idx_q))
                fault_d = 1'b1;
            if (ring_clr || exp_idx_q == 3'd5)
                exp_idx_d = 3'd0;
            else
                exp_idx_d = exp_idx_q + 3'd1;
            if (ring_clr || exp_idx_q == 3'd5)
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            if (t[3] && opcode == HLT_OP)
                hlt_d = 1'b1;
        end
    end

    always_comb begin
        con = rom_word;
        if (res || hlt_q || !t_legal)
            con = MW_IDLE;
    end

`ifdef SAP_EARLY_RING_CLR_EN
    // LDA finishes at T5; OUT and NOP-class opcodes have nothing after T4.
    always_comb begin
        ring_clr = 1'b0;
        if (!res && !hlt_q && t_legal) begin
            if (opcode == OP_LDA)
                ring_clr = t[4];
            else if (opcode != OP_ADD && opcode != OP_SUB && opcode != HLT_OP)
                ring_clr = t[3];
        end
    end
`else
    assign ring_clr = 1'b0;
`endif

    assign hlt       = hlt_q;
    assign fault     = fault_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: a driver emulates the ring counter
// and a reference model; a monitor compares every cycle's DUT outputs.
module tb_sap_control_sequencer;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic [5:0]    t = 6'd0;
    logic [3:0]    opcode = 4'h0;
    logic [11:0]   con;
    logic          hlt;
    logic          ring_clr;
    logic          fault;
    logic [CW-1:0] instr_cnt;

    sap_control_sequencer #(
        .CNT_W  (CW),
        .HLT_OP (4'hF),
        .OUT_OP (4'hE)
    ) dut (
        .clk       (clk),
        .res       (res),
        .t         (t),
        .opcode    (opcode),
        .con       (con),
        .hlt       (hlt),
        .ring_clr  (ring_clr),
        .fault     (fault),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [11:0]   con;
        logic          hlt;
        logic          fault;
        logic          rc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn   = 0;

    // Reference model: position within the instruction, halt/fault flags, count.
    bit m_hlt = 0;
    bit m_fault = 0;
    int m_exp = 0;
    int m_cnt = 0;
    logic [5:0] cur_t = 6'd0;
    logic [3:0] cur_op = 4'h0;
    bit         cur_res = 1;

    logic [11:0] fetch_tab [3] = '{12'h5E3, 12'hBE3, 12'h263};
    logic [11:0] lda_tab   [3] = '{12'h1A3, 12'h2C3, 12'h3E3};
    logic [11:0] add_tab   [3] = '{12'h1A3, 12'h2E1, 12'h3C7};
    logic [11:0] sub_tab   [3] = '{12'h1A3, 12'h2E1, 12'h3CF};
    logic [11:0] out_tab   [3] = '{12'h3F2, 12'h3E3, 12'h3E3};

    function automatic int pos_of(input logic [5:0] v);
        int n = 0;
        int p = -1;
        for (int i = 0; i < 6; i++) if (v[i]) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    function automatic logic [11:0] model_con(input logic [5:0] tv, input logic [3:0] op, input bit r);
        int p = pos_of(tv);
        if (r || m_hlt || p < 0) return 12'h3E3;
        if (p < 3) return fetch_tab[p];
        case (op)
            4'h0:    return lda_tab[p-3];
            4'h1:    return add_tab[p-3];
            4'h2:    return sub_tab[p-3];
            4'hE:    return out_tab[p-3];
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic bit model_rc(input logic [5:0] tv, input logic [3:0] op, input bit r);
        int p = pos_of(tv);
        if (r || m_hlt || p < 0) return 0;
`ifdef SAP_EARLY_RING_CLR_EN
        if (op == 4'h0) return p == 4;
        if (op == 4'h1 || op == 4'h2 || op == 4'hF) return 0;
        return p == 3;
`else
        return 0;
`endif
    endfunction

    // One clock: apply the edge to the model, then drive new inputs and log expectations.
    task automatic step(input logic [5:0] tv, input logic [3:0] op, input bit r);
        bit rc;
        exp_t e;
        @(posedge clk);
        if (!cur_res && !m_hlt) begin
            rc = model_rc(cur_t, cur_op, 0);
            if (cur_t !== (6'd1 << m_exp)) m_fault = 1;
            if (m_exp == 5 || rc) m_cnt = (m_cnt + 1) % (1 << CW);
            if (cur_t[3] && cur_op == 4'hF) m_hlt = 1;
            m_exp = rc ? 0 : (m_exp + 1) % 6;
        end
        #2;
        t = tv; opcode = op; res = r;
        cur_t = tv; cur_op = op; cur_res = r;
        if (r) begin m_hlt = 0; m_fault = 0; m_exp = 0; m_cnt = 0; end
        txn++;
        e.id = txn; e.con = model_con(tv, op, r); e.hlt = m_hlt; e.fault = m_fault;
        e.rc = model_rc(tv, op, r); e.cnt = CW'(m_cnt);
        q.push_back(e);
    endtask

    // Drive one instruction as a well-behaved ring counter would.
    task automatic run_instr(input logic [3:0] op);
        int p = 0;
        logic [5:0] tv;
        do begin
            tv = 6'd1 << p;
            step(tv, op, 0);
            p = model_rc(tv, op, 0) ? 0 : p + 1;
        end while (p != 0 && p < 6);
        $display("instr op=%h cnt=%0d hlt=%0d fault=%0d", op, m_cnt, m_hlt, m_fault);
    endtask

    task automatic check(input string name, input int id, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("con",       e.id, con,              e.con);
                check("hlt",       e.id, 12'(hlt),         12'(e.hlt));
                check("fault",     e.id, 12'(fault),       12'(e.fault));
                check("ring_clr",  e.id, 12'(ring_clr),    12'(e.rc));
                check("instr_cnt", e.id, 12'(instr_cnt),   12'(e.cnt));
            end
        end
    end

    logic [3:0] op_pool [7] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h3, 4'h7};

    initial begin : driver
        int p;
        logic [3:0] op;
        logic [5:0] tv;
        step(6'd0, 4'h0, 1);
        step(6'd1, 4'h0, 1);
        run_instr(4'h0);
        run_instr(4'h2);
        run_instr(4'h1);
        for (int i = 0; i < 5; i++) run_instr(4'h5);
        run_instr(4'hF);
        for (int i = 0; i < 3; i++) step(6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 0);
        step(6'd1, 4'h0, 1);
        run_instr(4'h0);
        run_instr(4'hE);
        // Out-of-order T3 where T2 is expected, then a correct tail.
        step(6'b000001, 4'h0, 0);
        step(6'b000100, 4'h0, 0);
        for (int k = 2; k < 6; k++) step(6'd1 << k, 4'h0, 0);
        run_instr(4'h1);
        step(6'd1, 4'h0, 1);
        run_instr(4'h2);

        for (int n = 0; n < 60; n++) begin
            op = op_pool[$urandom_range(0, 6)];
            p = 0;
            do begin
                tv = 6'd1 << p;
                if ($urandom_range(0, 24) == 0) tv = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 49) == 0) begin
                    step(6'd1, op, 1);
                    p = 0;
                end else begin
                    step(tv, op, 0);
                    p = model_rc(tv, op, 0) ? 0 : p + 1;
                end
            end while (p != 0 && p < 6);
            $display("instr op=%h cnt=%0d hlt=%0d fault=%0d", op, m_cnt, m_hlt, m_fault);
            if (m_hlt || m_fault) begin
                step(6'($urandom_range(0, 63)), op, 0);
                step(6'd1, 4'h0, 1);
            end
        end
        step(6'd1, 4'h0, 0);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
